// File: rtl/qoa_pkg.sv
// rtl/qoa_pkg.sv - shared state encoding, opcodes and slice layout for the QOA slice controller
package qoa_pkg;

    // Controller states
    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_LOAD_LMS   = 2'd1;
    localparam logic [1:0] ST_LOAD_SLICE = 2'd2;
    localparam logic [1:0] ST_DECODE     = 2'd3;

    // Opcodes recognised in IDLE
    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_LMS   = 8'h01;
    localparam logic [7:0] OP_SLICE = 8'h02;

    // Slice word layout: scale factor on top, residual 0 directly below it
    localparam int SLICE_W  = 64;
    localparam int SF_MSB   = 63;
    localparam int SF_LSB   = 60;
    localparam int RES_W    = 3;
    localparam int RES0_LSB = 57;

endpackage

// File: rtl/qoa_residual_sel.sv
// rtl/qoa_residual_sel.sv - picks residual code idx out of the 64-bit slice word
module qoa_residual_sel
    import qoa_pkg::*;
#(
    parameter int SLICE_SAMPLES = 20,
    parameter int IDX_W         = (SLICE_SAMPLES > 1) ? $clog2(SLICE_SAMPLES) : 1
) (
    input  logic [SLICE_W-1:0] slice,
    input  logic [IDX_W-1:0]   idx,
    output logic [RES_W-1:0]   code
);

    logic [6:0] bit_off;

    // Residual i sits 3*i bits below residual 0
    assign bit_off = 7'(idx) * 7'd3;
    assign code    = RES_W'(slice >> (7'(RES0_LSB) - bit_off));

endmodule

// File: rtl/qoa_slice_ctrl.sv
// rtl/qoa_slice_ctrl.sv - SPI byte stream to LMS loads and residual decode requests (QOA_SLICE_COUNT_EN enables slice_count)
module qoa_slice_ctrl
    import qoa_pkg::*;
#(
    parameter int SLICE_SAMPLES = 20,
    parameter int LMS_LEN       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        lms_wr_en,
    output logic [2:0]  lms_wr_idx,
    output logic [15:0] lms_wr_data,
    output logic        dec_req,
    input  logic        dec_ack,
    output logic [3:0]  dec_sf,
    output logic [2:0]  dec_code,
    output logic        busy,
    output logic        err,
    output logic [15:0] slice_count
);

    localparam int LMS_BYTES = 4 * LMS_LEN;
    localparam int CNT_W     = $clog2(LMS_BYTES);
    localparam int IDX_W     = (SLICE_SAMPLES > 1) ? $clog2(SLICE_SAMPLES) : 1;
    localparam logic [CNT_W-1:0] LMS_LAST = CNT_W'(LMS_BYTES - 1);
    localparam logic [IDX_W-1:0] RES_LAST = IDX_W'(SLICE_SAMPLES - 1);

    logic [1:0]         state;
    logic [CNT_W-1:0]   lms_cnt;
    logic [2:0]         slc_cnt;
    logic [IDX_W-1:0]   res_idx;
    logic [7:0]         lms_hi;
    logic [SLICE_W-1:0] slice_reg;

    assign busy    = (state != ST_IDLE);
    assign dec_req = (state == ST_DECODE);
    assign dec_sf  = slice_reg[SF_MSB:SF_LSB];

    qoa_residual_sel #(
        .SLICE_SAMPLES (SLICE_SAMPLES),
        .IDX_W         (IDX_W)
    ) u_residual_sel (
        .slice (slice_reg),
        .idx   (res_idx),
        .code  (dec_code)
    );

    // Main sequencer: opcode decode, LMS word assembly, slice shift-in, residual handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            lms_cnt     <= '0;
            slc_cnt     <= '0;
            res_idx     <= '0;
            lms_hi      <= '0;
            slice_reg   <= '0;
            lms_wr_en   <= 1'b0;
            lms_wr_idx  <= '0;
            lms_wr_data <= '0;
            err         <= 1'b0;
        end else begin
            lms_wr_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (byte_valid) begin
                        if (byte_data == OP_LMS) begin
                            state   <= ST_LOAD_LMS;
                            lms_cnt <= '0;
                        end else if (byte_data == OP_SLICE) begin
                            state   <= ST_LOAD_SLICE;
                            slc_cnt <= '0;
                        end else if (byte_data == OP_NOP) begin
                            err <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_LOAD_LMS: begin
                    if (byte_valid) begin
                        if (!lms_cnt[0]) begin
                            lms_hi <= byte_data;
                        end else begin
                            lms_wr_en   <= 1'b1;
                            lms_wr_idx  <= 3'(lms_cnt >> 1);
                            lms_wr_data <= {lms_hi, byte_data};
                        end
                        if (lms_cnt == LMS_LAST) begin
                            state   <= ST_LOAD_SLICE;
                            lms_cnt <= '0;
                            slc_cnt <= '0;
                        end else begin
                            lms_cnt <= lms_cnt + 1'b1;
                        end
                    end
                end
                ST_LOAD_SLICE: begin
                    if (byte_valid) begin
                        slice_reg <= {slice_reg[SLICE_W-9:0], byte_data};
                        if (slc_cnt == 3'd7) begin
                            state   <= ST_DECODE;
                            slc_cnt <= '0;
                            res_idx <= '0;
                        end else begin
                            slc_cnt <= slc_cnt + 3'd1;
                        end
                    end
                end
                default: begin
                    // ST_DECODE: incoming bytes have nowhere to go, flag the overrun
                    if (byte_valid) begin
                        err <= 1'b1;
                    end
                    if (dec_ack) begin
                        if (res_idx == RES_LAST) begin
                            state   <= ST_IDLE;
                            res_idx <= '0;
                        end else begin
                            res_idx <= res_idx + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

`ifdef QOA_SLICE_COUNT_EN
    logic        slice_done;
    logic [15:0] count_q;

    assign slice_done  = (state == ST_DECODE) && dec_ack && (res_idx == RES_LAST);
    assign slice_count = count_q;

    // Completed-slice counter, wraps naturally at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (slice_done) begin
            count_q <= count_q + 16'd1;
        end
    end
`else
    assign slice_count = 16'd0;
`endif

endmodule

// File: tb/tb_qoa_slice_ctrl.sv
// tb/tb_qoa_slice_ctrl.sv - scoreboard bench for qoa_slice_ctrl with randomized slices and LMS loads
module tb_qoa_slice_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        dec_ack = 1'b0;
    logic        lms_wr_en;
    logic [2:0]  lms_wr_idx;
    logic [15:0] lms_wr_data;
    logic        dec_req;
    logic [3:0]  dec_sf;
    logic [2:0]  dec_code;
    logic        busy;
    logic        err;
    logic [15:0] slice_count;

    qoa_slice_ctrl #(.SLICE_SAMPLES(20), .LMS_LEN(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .lms_wr_en   (lms_wr_en),
        .lms_wr_idx  (lms_wr_idx),
        .lms_wr_data (lms_wr_data),
        .dec_req     (dec_req),
        .dec_ack     (dec_ack),
        .dec_sf      (dec_sf),
        .dec_code    (dec_code),
        .busy        (busy),
        .err         (err),
        .slice_count (slice_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [18:0] lms_q[$];
    logic [6:0]  dec_q[$];
    int ack_mode = 0;
    int stall_cnt = 0;
    int model_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] exp_count();
`ifdef QOA_SLICE_COUNT_EN
        return 32'(model_count & 16'hFFFF);
`else
        return 32'd0;
`endif
    endfunction

    // Decoder acknowledge model: always, random, or a 5-cycle stall on the first code 3
    initial forever begin
        @(posedge clk);
        #1;
        if (ack_mode == 0) begin
            dec_ack = 1'b1;
        end else if (ack_mode == 1) begin
            dec_ack = 1'($urandom_range(0, 1));
        end else if (dec_req && dec_code == 3'd3 && stall_cnt < 5) begin
            dec_ack = 1'b0;
            stall_cnt++;
        end else begin
            dec_ack = 1'b1;
        end
    end

    // Monitor: pop expected LMS writes and residual handshakes as the DUT produces them
    initial forever begin
        logic [18:0] el;
        logic [6:0]  ed;
        @(negedge clk);
        if (rst_n) begin
            if (lms_wr_en) begin
                if (lms_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL lms_unexpected actual=idx%0d/%0h required=none", lms_wr_idx, lms_wr_data);
                end else begin
                    el = lms_q.pop_front();
                    check("lms_idx", 32'(lms_wr_idx), 32'(el[18:16]));
                    check("lms_data", 32'(lms_wr_data), 32'(el[15:0]));
                end
            end
            if (dec_req && dec_ack) begin
                if (dec_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dec_unexpected actual=code%0d required=none", dec_code);
                end else begin
                    ed = dec_q.pop_front();
                    check("dec_code", 32'(dec_code), 32'(ed[2:0]));
                    check("dec_sf", 32'(dec_sf), 32'(ed[6:3]));
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic maybe_gap(input bit gaps);
        if (gaps) idle($urandom_range(0, 2));
    endtask

    task automatic load_lms(input logic [15:0] w[8], input bit gaps);
        send_byte(8'h01);
        for (int i = 0; i < 8; i++) begin
            maybe_gap(gaps);
            send_byte(w[i][15:8]);
            maybe_gap(gaps);
            lms_q.push_back({3'(i), w[i]});
            send_byte(w[i][7:0]);
        end
    endtask

    // Reference: sf is the top nibble, residual i is the 3-bit field starting at bit 59-3i
    task automatic send_slice(input logic [63:0] s, input bit with_op, input bit gaps);
        if (with_op) send_byte(8'h02);
        for (int i = 0; i < 20; i++)
            dec_q.push_back({4'(s >> 60), 3'(s >> (57 - 3 * i))});
        for (int k = 7; k >= 0; k--) begin
            maybe_gap(gaps);
            send_byte(8'(s >> (8 * k)));
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 600) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=busy required=idle", name);
        end
    endtask

    task automatic finish_slice(input string name);
        wait_idle(name);
        model_count++;
        check({name, "_count"}, 32'(slice_count), exp_count());
        check({name, "_drained"}, 32'(dec_q.size()), 32'd0);
    endtask

    function automatic logic [63:0] cycling_slice();
        logic [63:0] s;
        s = 64'hA << 60;
        for (int i = 0; i < 20; i++) s = s | (64'(i % 8) << (57 - 3 * i));
        return s;
    endfunction

    initial begin
        logic [15:0] w[8];
        logic [63:0] s;
        int n;
        int req_cycles;
        int low_cycles;

        // Reset state
        #2;
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);
        check("rst_lms_en", 32'(lms_wr_en), 0);
        check("rst_dec_req", 32'(dec_req), 0);
        check("rst_outs", {lms_wr_idx, lms_wr_data, dec_sf, dec_code}, 0);
        check("rst_count", 32'(slice_count), 0);
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // LMS load 1..8, then the controller must already be in LOAD_SLICE
        for (int i = 0; i < 8; i++) w[i] = 16'(i + 1);
        load_lms(w, 1'b0);
        idle(2);
        check("lms_all_written", 32'(lms_q.size()), 0);
        check("lms_then_busy", 32'(busy), 1);
        s = {$urandom, $urandom};
        send_slice(s, 1'b0, 1'b0);
        finish_slice("after_lms");

        // Cycling residuals with ack tied high: 20 back-to-back requests
        ack_mode = 0;
        send_slice(cycling_slice(), 1'b1, 1'b0);
        req_cycles = 0;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            if (dec_req) req_cycles++;
            @(posedge clk);
            #1;
            n++;
        end
        check("req_cycles", 32'(req_cycles), 20);
        check("cyc_drained", 32'(dec_q.size()), 0);
        model_count++;
        check("cyc_count", 32'(slice_count), exp_count());

        // Five-cycle stall on code 3: code held, request held
        ack_mode = 2;
        stall_cnt = 0;
        send_slice(cycling_slice(), 1'b1, 1'b0);
        low_cycles = 0;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            if (!dec_ack) begin
                low_cycles++;
                check("stall_req", 32'(dec_req), 1);
                check("stall_code", 32'(dec_code), 3);
            end
            @(posedge clk);
            #1;
            n++;
        end
        check("stall_cycles", 32'(low_cycles), 5);
        check("stall_drained", 32'(dec_q.size()), 0);
        model_count++;

        // Bad opcode sets err, NOP clears it
        ack_mode = 1;
        send_byte(8'h7F);
        idle(1);
        check("badop_err", 32'(err), 1);
        check("badop_busy", 32'(busy), 0);
        send_byte(8'h00);
        idle(1);
        check("nop_clear", 32'(err), 0);

        // Byte arriving during DECODE is dropped and flagged
        s = {$urandom, $urandom};
        send_slice(s, 1'b1, 1'b1);
        idle(3);
        send_byte(8'h55);
        finish_slice("overrun");
        check("overrun_err", 32'(err), 1);
        send_byte(8'h00);
        idle(1);
        check("overrun_clear", 32'(err), 0);

        // Reset mid-DECODE
        s = {$urandom, $urandom};
        send_slice(s, 1'b1, 1'b0);
        idle(4);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_dec_req", 32'(dec_req), 0);
        check("arst_busy", 32'(busy), 0);
        dec_q.delete();
        model_count = 0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        check("arst_idle", 32'(busy), 0);
        check("arst_count", 32'(slice_count), 0);
        check("arst_outs", {lms_wr_en, lms_wr_idx, lms_wr_data, dec_sf, dec_code}, 0);

        // Reset mid-LMS load: partial words are discarded, fresh slice afterwards
        send_byte(8'h01);
        send_byte(8'h00);
        lms_q.push_back({3'd0, 16'h0005});
        send_byte(8'h05);
        send_byte(8'h12);
        idle(3);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        check("lrst_drained", 32'(lms_q.size()), 0);
        check("lrst_busy", 32'(busy), 0);
        s = {$urandom, $urandom};
        send_slice(s, 1'b1, 1'b1);
        finish_slice("lrst_slice");

        // Randomized mix of LMS loads and slices with random ack stalls
        for (int t = 0; t < 6; t++) begin
            ack_mode = 1;
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 8; i++) w[i] = 16'($urandom);
                load_lms(w, 1'b1);
                s = {$urandom, $urandom};
                send_slice(s, 1'b0, 1'b1);
            end else begin
                s = {$urandom, $urandom};
                send_slice(s, 1'b1, 1'b1);
            end
            finish_slice("rand");
            check("rand_lms_drained", 32'(lms_q.size()), 0);
            check("rand_err", 32'(err), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qoa_slice_ctrl.md
QOA_SLICE_CTRL -- requirements
Module: qoa_slice_ctrl

Interface
REQ-001 SHALL have parameter SLICE_SAMPLES, default 20, residual codes per slice.
REQ-002 SHALL have parameter LMS_LEN, default 4, taps each of history and weights.
REQ-003 SHALL have port clk  in  1  system clock.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port byte_valid  in  1  single-cycle strobe, byte_data valid.
REQ-006 SHALL have port byte_data  in  8  byte received from the SPI receiver.
REQ-007 SHALL have port lms_wr_en  out  1  single-cycle write strobe into the decoder LMS state.
REQ-008 SHALL have port lms_wr_idx  out  3  0-3 history[i], 4-7 weight[i-4].
REQ-009 SHALL have port lms_wr_data  out  16  signed word, big-endian assembled.
REQ-010 SHALL have port dec_req  out  1  residual decode request.
REQ-011 SHALL have port dec_ack  in  1  decoder accepted the current request.
REQ-012 SHALL have port dec_sf  out  4  slice scale factor.
REQ-013 SHALL have port dec_code  out  3  current residual code.
REQ-014 SHALL have port busy  out  1  high in every state except IDLE.
REQ-015 SHALL have port err  out  1  sticky bad-opcode or overrun flag.
REQ-016 SHALL have port slice_count  out  16  completed slices.

Function
REQ-017 SHALL implement states IDLE, LOAD_LMS, LOAD_SLICE, DECODE.
REQ-018 IDLE: byte 0x01 -> LOAD_LMS, 0x02 -> LOAD_SLICE, 0x00 ignored, other -> err set, stay IDLE.
REQ-019 LOAD_LMS SHALL take 4*LMS_LEN bytes, pairs high-then-low; lms_wr_en pulses the cycle after each low byte, idx 0..2*LMS_LEN-1 in order; after last pair -> LOAD_SLICE.
REQ-020 LOAD_SLICE SHALL shift 8 bytes MSB-first into a 64-bit register; after 8th byte -> DECODE the next cycle.
REQ-021 dec_sf SHALL equal slice bits 63:60, held constant throughout DECODE.
REQ-022 Residual i (0..SLICE_SAMPLES-1) SHALL be bits (59-3i):(57-3i).
REQ-023 DECODE: dec_req high with dec_code stable until dec_ack seen high on a clock edge; next code presented the following cycle with dec_req remaining high.
REQ-024 dec_ack while dec_req low SHALL be ignored.
REQ-025 After ack of code SLICE_SAMPLES-1: dec_req low next cycle, slice_count +1 (wraps 0xFFFF->0), -> IDLE.
REQ-026 byte_valid during DECODE SHALL drop the byte and set err.
REQ-027 err SHALL clear only on reset or opcode 0x00 in IDLE.
REQ-028 Each state SHALL accept at most one byte per cycle; no byte is lost outside DECODE.

Reset
REQ-029 Reset SHALL force IDLE; lms_wr_en, dec_req, busy, err = 0; lms_wr_idx, lms_wr_data, dec_sf, dec_code, slice_count = 0.
REQ-030 Reset mid-load or mid-DECODE SHALL abandon the slice with no further strobes; partial bytes discarded.

Configuration
REQ-031 With QOA_SLICE_COUNT_EN defined, slice_count SHALL count per REQ-025.
REQ-032 Without QOA_SLICE_COUNT_EN, slice_count SHALL be constant 0 and no counter flops SHALL be built.

Structure
REQ-033 State encoding, opcode constants (0x00/0x01/0x02), slice width 64, scale-factor field position SHALL live in shared package qoa_pkg.
REQ-034 Residual extraction (slice register + index -> 3-bit code) SHALL be sub-module qoa_residual_sel; everything else flat.

Verification
REQ-035 0x01, then 16 bytes 0x00,0x01..0x00,0x08 -> eight lms_wr_en pulses, idx 0..7, data 1..8, then LOAD_SLICE.
REQ-036 0x02 + slice 0xA0..00 with residuals 0..7 cycling, dec_ack tied 1 -> 20 consecutive dec_req cycles, dec_sf=0xA, codes 0,1,..7,0,..3, slice_count 1.
REQ-037 dec_ack low 5 cycles on code 3 -> dec_code held 3, dec_req high throughout, no code skipped.
REQ-038 Byte 0x7F in IDLE -> err=1, busy=0; then 0x00 -> err=0.
REQ-039 Byte during DECODE -> err=1, code sequence unaffected; rst_n low mid-DECODE -> dec_req=0 asynchronously, IDLE after release.
REQ-040 Build without QOA_SLICE_COUNT_EN, run 3 slices -> slice_count stays 0.
